// File: rtl/line_doubler.sv
// line_doubler: 2x scan doubler built on two ping-pong line banks.
//
// The write side fills one bank with the incoming line. At every line or
// frame boundary the banks swap, so the line that just completed becomes
// readable. The read side is random access: each input pixel is shown at two
// output columns and on two output rows. The read path can interpolate odd
// columns horizontally and can darken odd rows to give a scanline look.
//
// Parameters
//   DW   - pixel width; three equal channels of DW/3 bits, red in the LSBs.
//          DW must be a multiple of 3.
//   MAXW - maximum number of input pixels per line.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous, active-low reset
//   frame_start  one-cycle pulse at the start of an input frame
//   line_start   one-cycle pulse at the start of an input line
//   pix_valid    pix_in is valid this cycle
//   pix_in       input pixel
//   mode         bit0 = scanline darkening, bit1 = horizontal interpolation
//   rd_x         output pixel column
//   rd_odd       0 = even output row, 1 = odd output row
//   out_pixel    registered output pixel, valid 2 cycles after rd_x
//   line_ready   one-cycle pulse when a completed line becomes readable
//   line_count   completed lines in the current frame, saturating at 1023
//   overflow     sticky: an input pixel arrived beyond MAXW
module line_doubler #(
  parameter  int DW   = 15,
  parameter  int MAXW = 256,
  localparam int AW   = $clog2(MAXW)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_start,
  input  logic          line_start,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_in,
  input  logic [1:0]    mode,
  input  logic [AW:0]   rd_x,
  input  logic          rd_odd,
  output logic [DW-1:0] out_pixel,
  output logic          line_ready,
  output logic [9:0]    line_count,
  output logic          overflow
);

  localparam int          CW      = DW / 3;
  localparam logic [AW:0] MAXW_V  = (AW+1)'(MAXW);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic          wbank;      // bank being written; the other bank is read
  logic [AW:0]   wx;         // next write column, saturates at MAXW
  logic [AW:0]   rlen;       // pixel count of the readable line

  logic          swap;
  logic          wx_full;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;

  logic [DW-1:0] mem0 [MAXW];
  logic [DW-1:0] mem1 [MAXW];

  // frame_start behaves as a line boundary too; both together still mean a
  // single swap.
  assign swap    = frame_start | line_start;
  assign wx_full = (wx == MAXW_V);

  // A pixel arriving with the boundary pulse is the first pixel of the new
  // line, so it goes to column 0 of the bank that becomes the write bank.
  assign wr_bank = swap ? ~wbank : wbank;
  assign wr_addr = swap ? '0 : wx[AW-1:0];
  assign wr_en   = pix_valid & (swap | ~wx_full);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbank      <= 1'b0;
      wx         <= '0;
      rlen       <= '0;
      line_ready <= 1'b0;
      line_count <= '0;
      overflow   <= 1'b0;
    end else begin
      // An empty line still swaps banks, but it announces nothing.
      line_ready <= swap && (wx != '0);

      if (swap) begin
        wbank <= ~wbank;
        rlen  <= wx;
        wx    <= pix_valid ? ONE : '0;
      end else if (pix_valid) begin
        if (wx_full) overflow <= 1'b1;
        else         wx       <= wx + ONE;
      end

      if (frame_start) begin
        line_count <= '0;
        overflow   <= 1'b0;
      end else if (line_start && (wx != '0) && (line_count != CNT_MAX)) begin
        line_count <= line_count + 10'd1;
      end
    end
  end

  // NOTE: line storage has no reset. Stale contents are never visible,
  // because rlen = 0 after reset forces black output.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[wr_addr] <= pix_in;
      else         mem0[wr_addr] <= pix_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 1: address generation and registered RAM read
  // ---------------------------------------------------------------------------
  logic [AW-1:0] k;          // source pixel of this output column
  logic [AW-1:0] k1;         // right-hand neighbour, clamped to the last pixel
  logic [AW:0]   k_next;
  logic [AW-1:0] rlen_last;
  logic          blank;

  assign k         = rd_x[AW:1];
  assign k_next    = {1'b0, k} + ONE;
  assign rlen_last = AW'(rlen - ONE);
  assign blank     = ({1'b0, rd_x} >= {rlen, 1'b0});

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    k1 = '0;
    if (k_next < rlen)     k1 = k_next[AW-1:0];
    else if (rlen != '0)   k1 = rlen_last;
  end

  logic [DW-1:0] p0_q;
  logic [DW-1:0] p1_q;
  logic          blank_q;
  logic          interp_q;
  logic          dark_q;

  // wbank is sampled at the same edge as rd_x. A read issued in the swap
  // cycle therefore completes from the old read bank, and a read issued one
  // cycle later sees the new one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p0_q     <= '0;
      p1_q     <= '0;
      blank_q  <= 1'b0;
      interp_q <= 1'b0;
      dark_q   <= 1'b0;
    end else begin
      p0_q     <= wbank ? mem0[k]  : mem1[k];
      p1_q     <= wbank ? mem0[k1] : mem1[k1];
      blank_q  <= blank;
      interp_q <= mode[1] & rd_x[0];
      dark_q   <= mode[0] & rd_odd;
    end
  end

  // ---------------------------------------------------------------------------
  // Read stage 2: per-channel blend and darkening, registered output
  // ---------------------------------------------------------------------------
  logic [DW-1:0] blend;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [CW-1:0] avg;
    logic [CW-1:0] base;

    assign a    = p0_q[c*CW +: CW];
    assign b    = p1_q[c*CW +: CW];
    // The sum is one bit wider so the carry survives before the halving.
    assign avg  = CW'(({1'b0, a} + {1'b0, b}) >> 1);
    assign base = interp_q ? avg : a;
    assign blend[c*CW +: CW] = dark_q ? (base >> 1) : base;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_pixel <= '0;
    else          out_pixel <= blank_q ? '0 : blend;
  end

endmodule

// File: tb/tb_line_doubler.sv
// tb_line_doubler: self-checking bench for line_doubler.
//
// Two instances share the same stimulus: one with MAXW=256 and one with
// MAXW=4, which is used for the overflow and truncation cases. Each input
// line is modelled as a queue of pixels. The reference output pixel is
// computed from the readable line, the column, the row parity and the mode.
// One cycle is one negedge. At that negedge the bench checks the outputs,
// then drives new inputs and advances the model. A read is checked two
// cycles after it is issued.
module tb_line_doubler;

  localparam int CW     = 5;
  localparam int BIGW   = 256;
  localparam int SMALLW = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start = 1'b0;
  logic        line_start  = 1'b0;
  logic        pix_valid   = 1'b0;
  logic [14:0] pix_in      = '0;
  logic [1:0]  mode        = '0;
  logic [8:0]  rd_x        = '0;
  logic        rd_odd      = 1'b0;

  logic [14:0] out_big,   out_small;
  logic        lr_big,    lr_small;
  logic [9:0]  lc_big,    lc_small;
  logic        ovf_big,   ovf_small;

  always #5 clk = ~clk;

  line_doubler #(.DW(15), .MAXW(BIGW)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .line_start(line_start), .pix_valid(pix_valid), .pix_in(pix_in),
    .mode(mode), .rd_x(rd_x), .rd_odd(rd_odd), .out_pixel(out_big),
    .line_ready(lr_big), .line_count(lc_big), .overflow(ovf_big)
  );

  line_doubler #(.DW(15), .MAXW(SMALLW)) dut_small (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .line_start(line_start), .pix_valid(pix_valid), .pix_in(pix_in),
    .mode(mode), .rd_x(rd_x[2:0]), .rd_odd(rd_odd), .out_pixel(out_small),
    .line_ready(lr_small), .line_count(lc_small), .overflow(ovf_small)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [14:0] wr_q[$];      // pixels received for the line in progress
  logic [14:0] rd_q[$];      // pixels of the readable line
  int          lc_m;
  bit          ovf_b, ovf_s, lr_m;

  // Pipeline of expected read results: slot 1 is due at the current negedge.
  logic [14:0] pe_big[2], pe_small[2], pc_val[2];
  bit          pe_v[2], pc_has[2];

  function automatic logic [14:0] ref_pix(input int cap, input int x, input bit odd,
                                          input logic [1:0] md);
    int rl, k, k1, ca, cb, ch;
    logic [14:0] a, b, res;
    rl  = (rd_q.size() < cap) ? rd_q.size() : cap;
    res = '0;
    if (x >= 2 * rl) return res;
    k  = x / 2;
    k1 = (k + 1 < rl) ? k + 1 : rl - 1;
    a  = rd_q[k];
    b  = rd_q[k1];
    for (int c = 0; c < 3; c++) begin
      ca = int'((a >> (c * CW)) & 15'h1f);
      cb = int'((b >> (c * CW)) & 15'h1f);
      ch = (md[1] && (x % 2 == 1)) ? (ca + cb) / 2 : ca;
      if (md[0] && odd) ch = ch / 2;
      res = res | 15'(ch << (c * CW));
    end
    return res;
  endfunction

  task automatic model_apply(input bit fs, input bit ls, input bit pv, input logic [14:0] pin);
    bit sw;
    sw   = fs | ls;
    lr_m = sw && (wr_q.size() > 0);
    if (sw) begin
      if (ls && !fs && wr_q.size() > 0 && lc_m < 1023) lc_m++;
      rd_q = wr_q;
      wr_q.delete();
      if (pv) wr_q.push_back(pin);
    end else if (pv) begin
      if (wr_q.size() >= BIGW)   ovf_b = 1'b1;
      if (wr_q.size() >= SMALLW) ovf_s = 1'b1;
      wr_q.push_back(pin);
    end
    if (fs) begin
      lc_m  = 0;
      ovf_b = 1'b0;
      ovf_s = 1'b0;
    end
  endtask

  // One clock cycle: check the outputs due now, then drive this cycle's inputs.
  task automatic cycle(input bit fs, input bit ls, input bit pv, input logic [14:0] pin,
                       input int x, input bit odd, input logic [1:0] md,
                       input bit has_c = 1'b0, input logic [14:0] cval = '0);
    @(negedge clk);
    if (pe_v[1]) begin
      check("pix_big",   out_big,   pe_big[1]);
      check("pix_small", out_small, pe_small[1]);
      if (pc_has[1]) check("pix_const", out_big, pc_val[1]);
    end
    check("line_ready",   lr_big,    lr_m);
    check("line_ready_s", lr_small,  lr_m);
    check("line_count",   lc_big,    lc_m);
    check("line_count_s", lc_small,  lc_m);
    check("overflow",     ovf_big,   ovf_b);
    check("overflow_s",   ovf_small, ovf_s);

    pe_big[1]   = pe_big[0];
    pe_small[1] = pe_small[0];
    pe_v[1]     = pe_v[0];
    pc_has[1]   = pc_has[0];
    pc_val[1]   = pc_val[0];
    pe_big[0]   = ref_pix(BIGW, x, odd, md);
    pe_small[0] = ref_pix(SMALLW, x % 8, odd, md);
    pe_v[0]     = 1'b1;
    pc_has[0]   = has_c;
    pc_val[0]   = cval;

    frame_start = fs;
    line_start  = ls;
    pix_valid   = pv;
    pix_in      = pin;
    rd_x        = 9'(x);
    rd_odd      = odd;
    mode        = md;
    model_apply(fs, ls, pv, pin);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, '0, 0, 0, 2'b00);
  endtask

  // Reset is asserted between clock edges. The outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_pix",        out_big,   0);
    check("rst_pix_s",      out_small, 0);
    check("rst_line_ready", lr_big,    0);
    check("rst_line_count", lc_big,    0);
    check("rst_overflow",   ovf_big,   0);
    frame_start = 1'b0; line_start = 1'b0; pix_valid = 1'b0;
    rd_x = '0; rd_odd = 1'b0; mode = '0;
    wr_q.delete(); rd_q.delete();
    lc_m = 0; ovf_b = 1'b0; ovf_s = 1'b0; lr_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pe_big[i] = '0; pe_small[i] = '0; pe_v[i] = 1'b1; pc_has[i] = 1'b0; pc_val[i] = '0;
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  logic [14:0] px[4];
  logic [14:0] p3;

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    async_reset();

    // Four pixels, mode 00: each pixel appears twice, then black past the end.
    px = '{15'h001F, 15'h03E0, 15'h7C00, 15'h7FFF};
    cycle(1, 0, 0, '0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, px[i], 0, 0, 2'b00);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    for (int x = 0; x < 8; x++) cycle(0, 0, 0, '0, x, 0, 2'b00, 1'b1, px[x / 2]);
    cycle(0, 0, 0, '0, 8, 0, 2'b00, 1'b1, 15'h0000);
    idle(2);

    // Interpolation: the mid-point of black and white, and a clamped last pixel.
    p3 = 15'($urandom_range(0, 32767));
    cycle(0, 0, 1, 15'h0000, 0, 0, 2'b00);
    cycle(0, 0, 1, 15'h7FFF, 0, 0, 2'b00);
    cycle(0, 0, 1, 15'($urandom_range(0, 32767)), 0, 0, 2'b00);
    cycle(0, 0, 1, p3, 0, 0, 2'b00);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    cycle(0, 0, 0, '0, 1, 0, 2'b10, 1'b1, 15'h3DEF);
    cycle(0, 0, 0, '0, 7, 0, 2'b10, 1'b1, p3);
    idle(2);

    // Scanline darkening on odd rows only.
    cycle(0, 0, 1, 15'h7FFF, 0, 0, 2'b00);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    cycle(0, 0, 0, '0, 0, 1, 2'b01, 1'b1, 15'h3DEF);
    cycle(0, 0, 0, '0, 0, 0, 2'b01, 1'b1, 15'h7FFF);
    idle(2);

    // Six pixels into the MAXW=4 instance overflow it; frame_start clears.
    cycle(1, 0, 0, '0, 0, 0, 2'b00);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 15'($urandom_range(0, 32767)), 0, 0, 2'b00);
    idle(1);
    check("ovf_small_set", ovf_small, 1);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    for (int x = 0; x < 8; x++) cycle(0, 0, 0, '0, x, x % 2, 2'($urandom_range(0, 3)));
    cycle(1, 0, 0, '0, 0, 0, 2'b00);
    idle(1);
    check("ovf_small_cleared", ovf_small, 0);
    check("frame_count_zero", lc_big, 0);

    // A pixel coincident with line_start lands at column 0 of the new line.
    cycle(0, 1, 1, 15'h1234, 0, 0, 2'b00);
    cycle(0, 0, 1, 15'($urandom_range(0, 32767)), 0, 0, 2'b00);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    cycle(0, 0, 0, '0, 0, 0, 2'b00, 1'b1, 15'h1234);
    idle(2);

    // Overflow of the full-size instance; read the last stored pixel.
    cycle(1, 0, 0, '0, 0, 0, 2'b00);
    for (int i = 0; i < BIGW + 2; i++) cycle(0, 0, 1, 15'($urandom_range(0, 32767)), 0, 0, 2'b00);
    idle(1);
    check("ovf_big_set", ovf_big, 1);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    for (int x = 508; x < 512; x++) cycle(0, 0, 0, '0, x, 1, 2'($urandom_range(0, 3)));
    idle(2);

    // Reset in the middle of a line discards it; reads stay black.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 15'($urandom_range(1, 32767)), 0, 0, 2'b00);
    async_reset();
    for (int x = 0; x < 20; x++) cycle(0, 0, 0, '0, x, 0, 2'b00, 1'b1, 15'h0000);
    cycle(0, 0, 1, 15'h5555, 0, 0, 2'b00);
    cycle(0, 0, 1, 15'h2AAA, 0, 0, 2'b00);
    cycle(0, 1, 0, '0, 0, 0, 2'b00);
    for (int x = 0; x < 6; x++) cycle(0, 0, 0, '0, x, 0, 2'b00);
    idle(2);

    // Random traffic, with reads running alongside writes and swaps.
    repeat (1500) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0, 15'($urandom_range(0, 32767)),
            $urandom_range(0, 31), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    idle(2);

    // line_count saturates at 1023.
    cycle(1, 0, 0, '0, 0, 0, 2'b00);
    repeat (1030) begin
      cycle(0, 0, 1, 15'($urandom_range(0, 32767)), $urandom_range(0, 3), 0, 2'b00);
      cycle(0, 1, 0, '0, $urandom_range(0, 3), 0, 2'b00);
    end
    idle(2);
    check("line_count_sat", lc_big, 1023);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_doubler.md
LINE_DOUBLER -- requirements
Module: line_doubler

Interface
REQ-001 SHALL have parameter DW, default 15, meaning pixel width: three equal channels of DW/3 bits, red in the LSBs; DW SHALL be a multiple of 3.
REQ-002 SHALL have parameter MAXW, default 256, meaning the maximum input pixels per line; AW = clog2(MAXW).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of an input frame.
REQ-006 SHALL have port line_start, input, 1 bit: one-cycle pulse at the start of an input line.
REQ-007 SHALL have port pix_valid, input, 1 bit: pix_in is valid this cycle.
REQ-008 SHALL have port pix_in, input, DW bits: input pixel.
REQ-009 SHALL have port mode, input, 2 bits: bit0 selects scanline darkening, bit1 selects horizontal interpolation.
REQ-010 SHALL have port rd_x, input, AW+1 bits: output pixel column.
REQ-011 SHALL have port rd_odd, input, 1 bit: 0 = even output row, 1 = odd output row.
REQ-012 SHALL have port out_pixel, output, DW bits: registered output pixel.
REQ-013 SHALL have port line_ready, output, 1 bit: one-cycle pulse when a completed line becomes readable.
REQ-014 SHALL have port line_count, output, 10 bits: number of completed lines in the current frame.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag for input pixels beyond MAXW.

Function
REQ-016 SHALL hold two line banks of MAXW x DW each; the write bank is wbank and the read bank is !wbank.
REQ-017 On pix_valid with wx < MAXW, SHALL write pix_in to [wbank, wx] and then increment wx.
REQ-018 On pix_valid with wx == MAXW, SHALL drop the pixel and set overflow.
REQ-019 On line_start, SHALL latch rlen <= wx, toggle wbank and set wx to 0.
REQ-020 On line_start with wx > 0, SHALL pulse line_ready on the next cycle and increment line_count, saturating at 1023.
REQ-021 On line_start with wx == 0, SHALL still swap banks, set rlen to 0, and not pulse line_ready.
REQ-022 When line_start and pix_valid occur in the same cycle, pix_in SHALL be stored at address 0 of the new write bank, so that wx = 1 afterwards.
REQ-023 frame_start SHALL act as line_start, including the swap and the conditional line_ready pulse, and SHALL additionally set line_count to 0 and clear overflow.
REQ-024 When frame_start and line_start occur together, SHALL perform a single swap.
REQ-025 Source index SHALL be k = rd_x >> 1.
REQ-026 When rd_x >= 2*rlen, out_pixel SHALL be 0 (black).
REQ-027 With mode[1] = 0, the base pixel SHALL be P[k].
REQ-028 With mode[1] = 1 and even rd_x, the base pixel SHALL be P[k].
REQ-029 With mode[1] = 1 and odd rd_x, the base pixel SHALL be the per-channel (P[k] + P[k1]) >> 1 with k1 = min(k+1, rlen-1), using a DW/3+1-bit intermediate sum and truncation.
REQ-030 With mode[0] = 1 and rd_odd = 1, each channel of the base pixel SHALL be shifted right by 1; otherwise the base pixel SHALL be output unchanged.
REQ-031 Read latency SHALL be exactly 2 cycles from rd_x/rd_odd/mode to out_pixel: a registered RAM read, then a registered blend.
REQ-032 The read path SHALL be fully pipelined, accepting a new rd_x every cycle.
REQ-033 A bank swap SHALL take effect on reads issued in the cycle after the swap; reads already in flight SHALL complete from the old bank.
REQ-034 Writes SHALL never target the read bank.

Reset
REQ-035 While reset_n = 0, SHALL force wbank = 0, wx = 0, rlen = 0, line_count = 0, overflow = 0, line_ready = 0, out_pixel = 0 and all pipeline registers to 0.
REQ-036 After reset, SHALL output 0 for every rd_x until the first line_ready; RAM contents need not be reset.
REQ-037 Reset asserted mid-line SHALL discard the partial line.

Verification
REQ-038 SHALL check: DW=15, mode=00, write 4 pixels 0x001F, 0x03E0, 0x7C00, 0x7FFF, then line_start -> line_ready 1 cycle later; rd_x=0..7 yields each pixel twice 2 cycles later; rd_x=8 yields 0.
REQ-039 SHALL check: mode=10 with P0=0x0000, P1=0x7FFF -> rd_x=1 yields 0x3DEF; rd_x=7 (last pixel) yields P3 unchanged.
REQ-040 SHALL check: mode=01, rd_odd=1, pixel 0x7FFF -> 0x3DEF; rd_odd=0 -> 0x7FFF.
REQ-041 SHALL check: MAXW=4, 6 pixels written -> overflow=1 and rlen=4; frame_start -> overflow=0 and line_count=0.
REQ-042 SHALL check: line_start coincident with pix_valid carrying 0x1234 -> after the next line_start, rd_x=0 yields 0x1234.
REQ-043 SHALL check: reset_n pulsed low mid-line -> all outputs 0 asynchronously; rd_x sweep yields 0 until a new line completes.
